// File: rtl/example_producer.sv
// F2C traffic source: fills ring-buffer chunks with a known 64-bit pattern and keeps a running checksum.
// Define F2C_PRODUCER_LFSR_EN to use a 64-bit Galois LFSR pattern instead of the incrementing counter.
module example_producer #(
    parameter int CHUNK_NBITS = 7,
    parameter int PTR_NBITS   = 2
) (
    input  logic                   sysClk_in,
    input  logic                   sysRst_n_in,
    input  logic [PTR_NBITS-1:0]   wrPtr_in,
    input  logic [PTR_NBITS-1:0]   rdPtr_in,
    output logic                   wrEnable_out,
    output logic [CHUNK_NBITS-4:0] wrOffset_out,
    output logic [63:0]            wrData_out,
    output logic                   commit_out,
    output logic [63:0]            csData_out,
    output logic                   csValid_out,
    input  logic                   csReset_in,
    input  logic [31:0]            countInit_in
);

    localparam int OFF_W = CHUNK_NBITS - 3;
    localparam logic [OFF_W-1:0]     LAST_OFFSET    = {OFF_W{1'b1}};
    localparam logic [OFF_W-1:0]     OFF_ONE        = {{(OFF_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_NBITS-1:0] PTR_ONE        = {{(PTR_NBITS-1){1'b0}}, 1'b1};
    localparam logic [31:0]          COUNT_DISABLED = 32'hFFFF_FFFF;
`ifdef F2C_PRODUCER_LFSR_EN
    localparam logic [63:0]          PATTERN_SEED   = 64'h0000_0000_0000_0001;
`else
    localparam logic [63:0]          PATTERN_SEED   = 64'h0000_0000_0000_0000;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_COMMIT = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t                 state_r;
    logic [63:0]            pattern_r;
    logic [31:0]            gapCount_r;
    logic [PTR_NBITS-1:0]   wrPtrNext_s;
    logic                   ringFull_s;
    logic                   startOk_s;

    function automatic logic [63:0] nextPattern(input logic [63:0] cur);
`ifdef F2C_PRODUCER_LFSR_EN
        if (cur[0]) begin
            nextPattern = {1'b0, cur[63:1]} ^ 64'hD800_0000_0000_0000;
        end else begin
            nextPattern = {1'b0, cur[63:1]};
        end
`else
        nextPattern = cur + 64'd1;
`endif
    endfunction

    // Ring-full and chunk-start qualification; one slot stays empty so full and empty differ.
    always_comb begin
        wrPtrNext_s = wrPtr_in + PTR_ONE;
        ringFull_s  = (wrPtrNext_s == rdPtr_in);
        startOk_s   = (countInit_in != COUNT_DISABLED) && !ringFull_s;
    end

    // Chunk sequencer; the write offset register doubles as the in-chunk QW counter.
    always_ff @(posedge sysClk_in or negedge sysRst_n_in) begin
        if (!sysRst_n_in) begin
            state_r      <= S_IDLE;
            pattern_r    <= PATTERN_SEED;
            gapCount_r   <= 32'd0;
            wrEnable_out <= 1'b0;
            wrOffset_out <= {OFF_W{1'b0}};
            wrData_out   <= 64'd0;
            commit_out   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    commit_out <= 1'b0;
                    if (startOk_s) begin
                        state_r      <= S_WRITE;
                        wrEnable_out <= 1'b1;
                        wrOffset_out <= {OFF_W{1'b0}};
                        wrData_out   <= pattern_r;
                        pattern_r    <= nextPattern(pattern_r);
                    end else begin
                        wrEnable_out <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (wrOffset_out == LAST_OFFSET) begin
                        state_r      <= S_COMMIT;
                        wrEnable_out <= 1'b0;
                        commit_out   <= 1'b1;
                    end else begin
                        wrEnable_out <= 1'b1;
                        wrOffset_out <= wrOffset_out + OFF_ONE;
                        wrData_out   <= pattern_r;
                        pattern_r    <= nextPattern(pattern_r);
                    end
                end
                S_COMMIT: begin
                    // The transceiver bumps wrPtr_in on this edge, so the next IDLE sees it fresh.
                    // DISABLED is not treated as a gap length: go straight to IDLE and park there.
                    commit_out   <= 1'b0;
                    wrEnable_out <= 1'b0;
                    wrOffset_out <= {OFF_W{1'b0}};
                    if ((countInit_in == 32'd0) || (countInit_in == COUNT_DISABLED)) begin
                        state_r <= S_IDLE;
                    end else begin
                        gapCount_r <= countInit_in - 32'd1;
                        state_r    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    commit_out   <= 1'b0;
                    wrEnable_out <= 1'b0;
                    if (gapCount_r == 32'd0) begin
                        state_r <= S_IDLE;
                    end else begin
                        gapCount_r <= gapCount_r - 32'd1;
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    wrEnable_out <= 1'b0;
                    commit_out   <= 1'b0;
                end
            endcase
        end
    end

    // Running checksum of every QW presented on the write port; a clear keeps the concurrent QW.
    always_ff @(posedge sysClk_in or negedge sysRst_n_in) begin
        if (!sysRst_n_in) begin
            csData_out <= 64'd0;
        end else begin
            csData_out <= (csReset_in ? 64'd0 : csData_out) + (wrEnable_out ? wrData_out : 64'd0);
        end
    end

    // Checksum is only meaningful when the host has drained everything and no chunk is in flight.
    always_ff @(posedge sysClk_in or negedge sysRst_n_in) begin
        if (!sysRst_n_in) begin
            csValid_out <= 1'b0;
        end else begin
            csValid_out <= (wrPtr_in == rdPtr_in) && ((state_r == S_IDLE) || (state_r == S_WAIT));
        end
    end

endmodule

// File: tb/tb_example_producer.sv
// Directed bench for example_producer: scoreboard of expected QWs, transceiver/host pointer model.
module tb_example_producer;

    localparam logic [31:0] DISABLED = 32'hFFFF_FFFF;
`ifdef F2C_PRODUCER_LFSR_EN
    localparam logic [63:0] SEED = 64'h1;
`else
    localparam logic [63:0] SEED = 64'h0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wrPtr = 2'd0;
    logic [1:0]  rdPtr = 2'd0;
    logic [1:0]  rdHold = 2'd0;
    logic        autoDrain = 1'b0;
    logic        csReset = 1'b0;
    logic [31:0] countInit = DISABLED;

    logic        wrEnable_out;
    logic [3:0]  wrOffset_out;
    logic [63:0] wrData_out;
    logic        commit_out;
    logic [63:0] csData_out;
    logic        csValid_out;

    int          nCmp = 0;
    int          nErr = 0;
    int          cyc = 0;
    int          writeCount = 0;
    int          commitCount = 0;
    int          sinceCommit = 0;
    logic [3:0]  expOff = 4'd0;
    logic        commitPend = 1'b0;
    logic [63:0] expQ[$];
    int          commitCycle[$];
    logic [63:0] obsData[16];
    logic [63:0] pushed[16];
    logic [63:0] modelPat = SEED;
    logic [63:0] modelSum = 64'd0;

    example_producer #(.CHUNK_NBITS(7), .PTR_NBITS(2)) dut (
        .sysClk_in   (clk),
        .sysRst_n_in (rst_n),
        .wrPtr_in    (wrPtr),
        .rdPtr_in    (rdPtr),
        .wrEnable_out(wrEnable_out),
        .wrOffset_out(wrOffset_out),
        .wrData_out  (wrData_out),
        .commit_out  (commit_out),
        .csData_out  (csData_out),
        .csValid_out (csValid_out),
        .csReset_in  (csReset),
        .countInit_in(countInit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [63:0] modelNext(input logic [63:0] p);
`ifdef F2C_PRODUCER_LFSR_EN
        return {1'b0, p[63:1]} ^ (p[0] ? 64'hD800_0000_0000_0000 : 64'h0);
`else
        return p + 64'd1;
`endif
    endfunction

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transceiver and host: bump wrPtr after each commit, optionally drain rdPtr right behind it.
    always begin
        @(negedge clk);
        commitPend = commit_out;
        @(posedge clk);
        #1;
        if (!rst_n) wrPtr = 2'd0;
        else if (commitPend) wrPtr = wrPtr + 2'd1;
        rdPtr = autoDrain ? wrPtr : rdHold;
    end

    // Scoreboard monitor: every write must match the next expected QW and offset.
    always @(negedge clk) begin
        if (!rst_n) begin
            expOff = 4'd0;
            sinceCommit = 0;
        end else begin
            if (wrEnable_out) begin
                writeCount++;
                check64("write_expected", 64'(wrEnable_out), 64'(expQ.size() != 0));
                if (expQ.size() != 0) begin
                    check64("wr_data", wrData_out, expQ.pop_front());
                    check64("wr_offset", 64'(wrOffset_out), 64'(expOff));
                    obsData[expOff] = wrData_out;
                    expOff = expOff + 4'd1;
                    sinceCommit++;
                end
            end
            if (commit_out) begin
                commitCount++;
                commitCycle.push_back(cyc);
                check64("commit_full_chunk", 64'(sinceCommit), 64'd16);
                sinceCommit = 0;
            end
        end
    end

    task automatic pushChunk();
        for (int i = 0; i < 16; i++) begin
            pushed[i] = modelPat;
            expQ.push_back(modelPat);
            modelSum = modelSum + modelPat;
            modelPat = modelNext(modelPat);
        end
    endtask

    task automatic waitWrite(input string tag);
        int n0 = writeCount;
        int k = 0;
        while (writeCount == n0 && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        check64({tag, "_started"}, 64'(writeCount > n0), 64'd1);
    endtask

    task automatic waitCommits(input int target, input int budget, input string tag);
        int k = 0;
        while (commitCount < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check64({tag, "_commits"}, 64'(commitCount), 64'(target));
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        countInit = DISABLED;
        csReset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        modelPat = SEED;
        modelSum = 64'd0;
    endtask

    initial begin
        int base;
        int wbase;
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check64("rst_wrEnable", 64'(wrEnable_out), 64'd0);
        check64("rst_commit", 64'(commit_out), 64'd0);
        check64("rst_wrOffset", 64'(wrOffset_out), 64'd0);
        check64("rst_wrData", wrData_out, 64'd0);
        check64("rst_csData", csData_out, 64'd0);
        rst_n = 1'b1;

        // T3a: disabled producer stays silent
        repeat (1000) @(negedge clk);
        #1;
        check64("t3_no_writes", 64'(writeCount), 64'd0);
        check64("t3_no_commits", 64'(commitCount), 64'd0);
        check64("t3_csValid_idle", 64'(csValid_out), 64'd1);

        // T1: single chunk, host drains immediately
        autoDrain = 1'b1;
        pushChunk();
        countInit = 32'd0;
        waitWrite("t1");
        countInit = DISABLED;
        waitCommits(1, 40, "t1");
        repeat (4) @(negedge clk);
        #1;
        check64("t1_writes", 64'(writeCount), 64'd16);
        check64("t1_csData", csData_out, modelSum);
`ifdef F2C_PRODUCER_LFSR_EN
        check64("t6_qw0", obsData[0], 64'h1);
        check64("t6_qw1", obsData[1], 64'hD800_0000_0000_0000);
`else
        check64("t1_csData_120", csData_out, 64'd120);
        check64("t1_qw0", obsData[0], 64'd0);
        check64("t1_qw15", obsData[15], 64'd15);
`endif
        check64("t1_csValid", 64'(csValid_out), 64'd1);
        check64("t1_commits_total", 64'(commitCount), 64'd1);

        // T2: host never drains, ring fills after 3 chunks
        autoDrain = 1'b0;
        rdHold = 2'd0;
        applyReset();
        base = commitCount;
        wbase = writeCount;
        pushChunk(); pushChunk(); pushChunk();
        countInit = 32'd0;
        waitCommits(base + 3, 90, "t2");
        repeat (40) @(negedge clk);
        #1;
        check64("t2_stall_commits", 64'(commitCount), 64'(base + 3));
        check64("t2_stall_writes", 64'(writeCount - wbase), 64'd48);
        check64("t2_csData", csData_out, modelSum);
`ifndef F2C_PRODUCER_LFSR_EN
        check64("t2_csData_1128", csData_out, 64'd1128);
`endif
        check64("t2_csValid_full", 64'(csValid_out), 64'd0);
        pushChunk();
        rdHold = 2'd1;
        waitCommits(base + 4, 60, "t2_fourth");
        countInit = DISABLED;
        repeat (3) @(negedge clk);
        #1;
        check64("t2_fourth_qw0", obsData[0], pushed[0]);
        check64("t2_csData_final", csData_out, modelSum);

        // T4: commit spacing with gap 5, then gap 0
        autoDrain = 1'b1;
        base = commitCount;
        pushChunk(); pushChunk(); pushChunk();
        countInit = 32'd5;
        waitCommits(base + 3, 100, "t4_gap5");
        countInit = DISABLED;
        check64("t4_gap5_a", 64'(commitCycle[base + 1] - commitCycle[base]), 64'd23);
        check64("t4_gap5_b", 64'(commitCycle[base + 2] - commitCycle[base + 1]), 64'd23);
        repeat (20) @(negedge clk);
        #1;
        base = commitCount;
        pushChunk(); pushChunk(); pushChunk();
        countInit = 32'd0;
        waitCommits(base + 3, 80, "t4_gap0");
        countInit = DISABLED;
        check64("t4_gap0_a", 64'(commitCycle[base + 1] - commitCycle[base]), 64'd18);
        check64("t4_gap0_b", 64'(commitCycle[base + 2] - commitCycle[base + 1]), 64'd18);
        repeat (10) @(negedge clk);
        #1;
        check64("t4_csData", csData_out, modelSum);

        // T3b: DISABLED asserted mid-chunk still yields exactly one commit
        base = commitCount;
        wbase = writeCount;
        pushChunk();
        countInit = 32'd7;
        waitWrite("t3b");
        countInit = DISABLED;
        waitCommits(base + 1, 40, "t3b");
        repeat (60) @(negedge clk);
        #1;
        check64("t3b_one_commit", 64'(commitCount), 64'(base + 1));
        check64("t3b_writes", 64'(writeCount - wbase), 64'd16);

        // T5: checksum clear on QW 3, reset at QW 7
        applyReset();
        pushChunk();
        countInit = 32'd0;
        k = 0;
        while (!(wrEnable_out && wrOffset_out == 4'd3) && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        csReset = 1'b1;
        @(posedge clk);
        #1;
        csReset = 1'b0;
        check64("t5_csData_after_clear", csData_out, pushed[3]);
`ifndef F2C_PRODUCER_LFSR_EN
        check64("t5_csData_3", csData_out, 64'd3);
`endif
        check64("t5_csValid_busy", 64'(csValid_out), 64'd0);
        base = commitCount;
        wbase = writeCount;
        k = 0;
        while (!(wrEnable_out && wrOffset_out == 4'd7) && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        rst_n = 1'b0;
        countInit = DISABLED;
        check64("t5_writes_before_rst", 64'(writeCount - wbase), 64'd4);
        expQ.delete();
        repeat (3) @(negedge clk);
        #1;
        check64("t5_rst_wrEnable", 64'(wrEnable_out), 64'd0);
        check64("t5_rst_csData", csData_out, 64'd0);
        check64("t5_no_commit", 64'(commitCount), 64'(base));
        rst_n = 1'b1;
        modelPat = SEED;
        modelSum = 64'd0;
        pushChunk();
        countInit = 32'd0;
        waitWrite("t5_restart");
        countInit = DISABLED;
        waitCommits(base + 1, 40, "t5_restart");
        repeat (4) @(negedge clk);
        #1;
        check64("t5_qw0_after_rst", obsData[0], SEED);
        check64("t5_csData_final", csData_out, modelSum);
        check64("scoreboard_drained", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
        $finish;
    end

endmodule
